encrypter_out: RTL and testbench

- Downstream neighbour of the encrypter input packer.
- Takes each ciphertext block from the modular-exponentiation unit. Each block is n_len bits wide, LSB-first.
- Re-serializes the blocks into a continuous bit stream and repacks it into bytes for the UART transmitter.
- On end-of-transmission, flushes any partial byte zero-padded, then signals done.

---
 rtl/crypt_pkg.sv | 27 ++
 rtl/bit_byte_packer.sv | 60 ++++++
 rtl/encrypter_out.sv | 192 +++++++++++++++++++
 tb/tb_encrypter_out.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// Shared definitions for the encrypter datapath.
// Holds the default word widths, the largest supported modulus length, the
// encrypter_out FSM state encoding and the modulus-length clamp helper.
package crypt_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefByteW = 8;
   localparam int unsigned MaxNlen  = 32;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StWaitBlk  = 3'd1,
      StShift    = 3'd2,
      StSend     = 3'd3,
      StFlush    = 3'd4,
      StSendLast = 3'd5
   } enc_out_state_e;

   // Out-of-range modulus lengths (0 or above MaxNlen) fall back to MaxNlen.
   function automatic logic [5:0] clamp_nlen(input logic [7:0] n);
      if (n == 8'd0 || n > 8'(MaxNlen)) begin
         return 6'(MaxNlen);
      end
      return n[5:0];
   endfunction

endpackage

// File: rtl/bit_byte_packer.sv
// Shift-in register that assembles a serial bit stream into bytes.
// Bits enter at the MSB and move toward bit 0, so the first bit pushed after a
// clear ends up in bit 0 once the byte is full.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear_i     empty the byte and reset the count (highest priority)
//   push_i      shift bit_i in
//   bit_i       data bit for push_i
//   pad_i       shift a zero in (used to finish a partial byte)
//   byte_o      current byte contents
//   cnt_o       number of bits held, 0..BYTE_W
//   full_o      cnt_o == BYTE_W
module bit_byte_packer #(
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic              bit_i,
   input  logic              pad_i,
   output logic [BYTE_W-1:0] byte_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              full_o
);

   logic [BYTE_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (push_i) begin
         buf_d = {bit_i, buf_q[BYTE_W-1:1]};
         cnt_d = cnt_q + 1'b1;
      end else if (pad_i) begin
         buf_d = {1'b0, buf_q[BYTE_W-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign byte_o = buf_q;
   assign cnt_o  = cnt_q;
   assign full_o = (cnt_q == CNT_W'(BYTE_W));

endmodule

// File: rtl/encrypter_out.sv
// Ciphertext output serializer: takes n_len-bit blocks from the modular
// exponentiation unit, streams them LSB-first and repacks the stream into bytes
// for the UART transmitter. On end-of-transmission a partial byte is zero-padded
// and sent, then done pulses.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   start_in      begin a session, latching n_len_in (0 or >32 means 32)
//   fme_done      fme_data_out holds a new ciphertext block
//   eot_in        no further blocks this session
//   tx_busy       UART busy; tx_start is never raised while it is high
//   tx_start      tx_data is a new byte (one cycle)
//   tx_data       byte to transmit, held until the next tx_start
//   busy          session in progress
//   done          one-cycle pulse once the final byte has been handed over
//   overrun       (ENC_OUT_OVERRUN_EN only) sticky: a block arrived while not
//                 waiting for one and was dropped; cleared by start_in
// Optional feature macro: ENC_OUT_OVERRUN_EN
module encrypter_out
   import crypt_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned BYTE_W = DefByteW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_in,
   input  logic [7:0]        n_len_in,
   input  logic              fme_done,
   input  logic [DATA_W-1:0] fme_data_out,
   input  logic              eot_in,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic              busy,
`ifdef ENC_OUT_OVERRUN_EN
   output logic              overrun,
`endif
   output logic              done
);

   localparam int unsigned CntW = 4;
   localparam logic [CntW-1:0] LastBit = CntW'(BYTE_W - 1);

   enc_out_state_e    state_q, state_d;
   logic [5:0]        n_len_q, n_len_d;
   logic [DATA_W-1:0] blk_q, blk_d;
   logic [5:0]        blk_cnt_q, blk_cnt_d;
   logic              eot_seen_q, eot_seen_d;
   logic              done_q, done_d;
   logic [BYTE_W-1:0] tx_data_q;

   logic              pk_clear, pk_push, pk_pad, pk_full;
   logic [BYTE_W-1:0] pk_byte;
   logic [CntW-1:0]   pk_cnt;

   bit_byte_packer #(
      .BYTE_W (BYTE_W),
      .CNT_W  (CntW)
   ) u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (pk_clear),
      .push_i  (pk_push),
      .bit_i   (blk_q[0]),
      .pad_i   (pk_pad),
      .byte_o  (pk_byte),
      .cnt_o   (pk_cnt),
      .full_o  (pk_full)
   );

   always_comb begin
      state_d    = state_q;
      n_len_d    = n_len_q;
      blk_d      = blk_q;
      blk_cnt_d  = blk_cnt_q;
      eot_seen_d = eot_seen_q;
      done_d     = 1'b0;
      pk_clear   = 1'b0;
      pk_push    = 1'b0;
      pk_pad     = 1'b0;
      tx_start   = 1'b0;

      if (state_q != StIdle && eot_in) begin
         eot_seen_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start_in) begin
               n_len_d    = clamp_nlen(n_len_in);
               eot_seen_d = 1'b0;
               pk_clear   = 1'b1;
               state_d    = StWaitBlk;
            end
         end
         StWaitBlk: begin
            // A block wins over a same-cycle eot; eot_seen is still recorded.
            if (fme_done) begin
               blk_d     = fme_data_out;
               blk_cnt_d = n_len_q;
               state_d   = StShift;
            end else if (eot_seen_q) begin
               state_d = StFlush;
            end
         end
         StShift: begin
            pk_push   = 1'b1;
            blk_d     = blk_q >> 1;
            blk_cnt_d = blk_cnt_q - 6'd1;
            if (pk_cnt == LastBit) begin
               state_d = StSend;
            end else if (blk_cnt_q == 6'd1) begin
               state_d = StWaitBlk;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               pk_clear = 1'b1;
               state_d  = (blk_cnt_q != 6'd0) ? StShift : StWaitBlk;
            end
         end
         StFlush: begin
            if (pk_cnt == '0) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               pk_pad = 1'b1;
               if (pk_cnt == LastBit) begin
                  state_d = StSendLast;
               end
            end
         end
         StSendLast: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               pk_clear = 1'b1;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         n_len_q    <= '0;
         blk_q      <= '0;
         blk_cnt_q  <= '0;
         eot_seen_q <= 1'b0;
         done_q     <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         n_len_q    <= n_len_d;
         blk_q      <= blk_d;
         blk_cnt_q  <= blk_cnt_d;
         eot_seen_q <= eot_seen_d;
         done_q     <= done_d;
         if (tx_start) begin
            tx_data_q <= pk_byte;
         end
      end
   end

   // Present the byte combinationally on the handshake cycle, then hold it.
   assign tx_data = tx_start ? pk_byte : tx_data_q;
   assign busy    = (state_q != StIdle);
   assign done    = done_q;

`ifdef ENC_OUT_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (state_q == StIdle && start_in) begin
         overrun_q <= 1'b0;
      end else if (fme_done && state_q != StWaitBlk) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`endif

   logic unused_full;
   assign unused_full = pk_full;

endmodule

// File: tb/tb_encrypter_out.sv
module tb_encrypter_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_in;
   logic [7:0]  n_len_in;
   logic        fme_done;
   logic [31:0] fme_data_out;
   logic        eot_in;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        done;
`ifdef ENC_OUT_OVERRUN_EN
   logic        overrun;
`endif

   always #5 clk = ~clk;

   encrypter_out #(
      .DATA_W (32),
      .BYTE_W (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_in     (start_in),
      .n_len_in     (n_len_in),
      .fme_done     (fme_done),
      .fme_data_out (fme_data_out),
      .eot_in       (eot_in),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .busy         (busy),
`ifdef ENC_OUT_OVERRUN_EN
      .overrun      (overrun),
`endif
      .done         (done)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int tx_cnt   = 0;
   int done_cnt = 0;
   int last_tx_cyc = -1;
   int exp_done = 0;
   int model_nlen = 32;

   logic [7:0] exp_q[$];
   bit         bits_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference stream model: session bit k lands in byte k/8, bit k%8.
   task automatic model_pack(input logic [31:0] d);
      logic [7:0] b;
      for (int i = 0; i < model_nlen; i++) bits_q.push_back(d[i]);
      while (bits_q.size() >= 8) begin
         for (int j = 0; j < 8; j++) b[j] = bits_q.pop_front();
         exp_q.push_back(b);
      end
   endtask

   task automatic model_eot();
      logic [7:0] b;
      if (bits_q.size() > 0) begin
         b = '0;
         for (int j = 0; bits_q.size() > 0; j++) b[j] = bits_q.pop_front();
         exp_q.push_back(b);
      end
      exp_done++;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_session(input logic [7:0] n);
      model_nlen = (n == 0 || n > 32) ? 32 : int'(n);
      bits_q.delete();
      n_len_in = n;
      start_in = 1'b1;
      step(1);
      start_in = 1'b0;
      step(1);
   endtask

   task automatic send_block(input logic [31:0] d);
      model_pack(d);
      fme_data_out = d;
      fme_done = 1'b1;
      step(1);
      fme_done = 1'b0;
      step(48);
   endtask

   task automatic end_session();
      model_eot();
      eot_in = 1'b1;
      step(1);
      eot_in = 1'b0;
      step(30);
   endtask

   task automatic check_session_end(input string tag);
      check_val({tag, "_queue_left"}, 32'(exp_q.size()), 0);
      check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
      check_val({tag, "_busy_after"}, {31'b0, busy}, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Output monitor / scoreboard pop.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            check_val("tx_while_busy", {31'b0, tx_busy}, 0);
            if (exp_q.size() == 0) begin
               check_val("tx_expected", 32'(exp_q.size()), 1);
            end else begin
               check_val("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      int tx0, done0, c_drop;
      rst_n = 1'b0;
      start_in = 1'b0;
      n_len_in = 8'd0;
      fme_done = 1'b0;
      fme_data_out = '0;
      eot_in = 1'b0;
      tx_busy = 1'b0;
      step(3);
      check_val("rst_busy", {31'b0, busy}, 0);
      check_val("rst_done", {31'b0, done}, 0);
      check_val("rst_tx_start", {31'b0, tx_start}, 0);
      check_val("rst_tx_data", {24'b0, tx_data}, 0);
      rst_n = 1'b1;
      step(2);

      // Reset with 5 bits accumulated: nothing sent, nothing flushed.
      start_session(8'd8);
      check_val("sess_busy", {31'b0, busy}, 1);
      fme_data_out = 32'h1F;
      fme_done = 1'b1;
      step(1);
      fme_done = 1'b0;
      step(5);
      tx0 = tx_cnt;
      done0 = done_cnt;
      rst_n = 1'b0;
      step(1);
      check_val("midrst_busy", {31'b0, busy}, 0);
      check_val("midrst_done", {31'b0, done}, 0);
      rst_n = 1'b1;
      step(20);
      check_val("midrst_no_tx", 32'(tx_cnt), 32'(tx0));
      check_val("midrst_no_done", 32'(done_cnt), 32'(done0));

      // One exact byte, no padding byte.
      tx0 = tx_cnt;
      start_session(8'd8);
      send_block(32'h0000_00A5);
      end_session();
      check_session_end("n8");
      check_val("n8_tx_cnt", 32'(tx_cnt - tx0), 1);

      // Blocks straddling byte boundaries.
      tx0 = tx_cnt;
      start_session(8'd12);
      send_block(32'h0000_0ABC);
      send_block(32'h0000_0123);
      end_session();
      check_session_end("n12");
      check_val("n12_tx_cnt", 32'(tx_cnt - tx0), 3);

      // Partial byte flushed with zero padding.
      start_session(8'd5);
      send_block(32'h0000_001F);
      end_session();
      check_session_end("n5");

      // n_len_in = 0 clamps to 32.
      tx0 = tx_cnt;
      start_session(8'd0);
      send_block(32'hDEAD_BEEF);
      end_session();
      check_session_end("n0");
      check_val("n0_tx_cnt", 32'(tx_cnt - tx0), 4);

      // tx_busy holds off the handshake.
      start_session(8'd8);
      tx0 = tx_cnt;
      model_pack(32'hFF);
      fme_data_out = 32'hFF;
      fme_done = 1'b1;
      tx_busy = 1'b1;
      step(1);
      fme_done = 1'b0;
      step(19);
      check_val("busy_held_off", 32'(tx_cnt), 32'(tx0));
      tx_busy = 1'b0;
      c_drop = cyc;
      step(3);
      check_val("busy_release_cyc", 32'(last_tx_cyc), 32'(c_drop));
      check_val("busy_tx_cnt", 32'(tx_cnt - tx0), 1);
      end_session();
      check_session_end("busy");

      // Second block arrives mid-shift and is dropped.
      tx0 = tx_cnt;
      start_session(8'd16);
      model_pack(32'hBEEF);
      fme_data_out = 32'hBEEF;
      fme_done = 1'b1;
      step(1);
      fme_done = 1'b0;
      step(2);
      fme_data_out = 32'h1234;
      fme_done = 1'b1;
      step(1);
      fme_done = 1'b0;
      step(48);
`ifdef ENC_OUT_OVERRUN_EN
      check_val("overrun_set", {31'b0, overrun}, 1);
`endif
      end_session();
      check_session_end("ovr");
      check_val("ovr_tx_cnt", 32'(tx_cnt - tx0), 2);
      start_session(8'd8);
`ifdef ENC_OUT_OVERRUN_EN
      check_val("overrun_clr", {31'b0, overrun}, 0);
`endif
      end_session();
      check_session_end("empty");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
